// File: rtl/fp_maxmin_pipe.sv
// fp_maxmin_pipe: pipelined signed float max/min finder with channel indices, NaN flag and valid/ready flow control
module fp_maxmin_pipe #(
    parameter int N_CH = 3,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int DW = 1 + EXP_W + MAN_W,
    localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 in_ready,
    input  logic [N_CH*DW-1:0]   data_in,
    output logic                 valid_out,
    input  logic                 out_ready,
    output logic [DW-1:0]        max,
    output logic [DW-1:0]        min,
    output logic [IDX_W-1:0]     max_idx,
    output logic [IDX_W-1:0]     min_idx,
    output logic                 nan
);
    localparam int L = $clog2(N_CH);
    localparam int P = 1 << L;
    localparam logic [DW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, MAN_W'(1) << (MAN_W - 1)};

    logic             adv;
    logic [L:0]       vld;
    logic [DW-1:0]    mx_q [L+1][P];
    logic [DW-1:0]    mn_q [L+1][P];
    logic [IDX_W-1:0] mxi_q [L+1][P];
    logic [IDX_W-1:0] mni_q [L+1][P];
    logic             pr_q [L+1][P];
    logic             nn_q [L+1][P];
    logic [DW-1:0]    mx_d [L+1][P];
    logic [DW-1:0]    mn_d [L+1][P];
    logic [IDX_W-1:0] mxi_d [L+1][P];
    logic [IDX_W-1:0] mni_d [L+1][P];
    logic             pr_d [L+1][P];
    logic             nn_d [L+1][P];

    // -0 folds onto +0 so signed zeros tie and the lower index wins
    function automatic logic [DW-1:0] key(input logic [DW-1:0] v);
        return (v[DW-1] && |v[DW-2:0]) ? {1'b0, ~v[DW-2:0]} : {1'b1, v[DW-2:0]};
    endfunction

    function automatic logic is_nan(input logic [DW-1:0] v);
        return &v[DW-2:MAN_W] && |v[MAN_W-1:0];
    endfunction

    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < N_CH) begin : g_ch
            assign mx_d[0][j]  = data_in[j*DW +: DW];
            assign mn_d[0][j]  = data_in[j*DW +: DW];
            assign mxi_d[0][j] = IDX_W'(j);
            assign mni_d[0][j] = IDX_W'(j);
            assign pr_d[0][j]  = 1'b1;
            assign nn_d[0][j]  = is_nan(data_in[j*DW +: DW]);
        end else begin : g_pad
            assign mx_d[0][j]  = '0;
            assign mn_d[0][j]  = '0;
            assign mxi_d[0][j] = '0;
            assign mni_d[0][j] = '0;
            assign pr_d[0][j]  = 1'b0;
            assign nn_d[0][j]  = 1'b0;
        end
    end

    // The right child only ever covers higher indices, so it needs a strict win
    for (genvar i = 1; i <= L; i++) begin : g_lvl
        for (genvar j = 0; j < P; j++) begin : g_node
            if (j < (P >> i)) begin : g_cmp
                logic tmx, tmn;
                assign tmx = pr_q[i-1][2*j+1] && key(mx_q[i-1][2*j+1]) > key(mx_q[i-1][2*j]);
                assign tmn = pr_q[i-1][2*j+1] && key(mn_q[i-1][2*j+1]) < key(mn_q[i-1][2*j]);
                assign mx_d[i][j]  = tmx ? mx_q[i-1][2*j+1] : mx_q[i-1][2*j];
                assign mxi_d[i][j] = tmx ? mxi_q[i-1][2*j+1] : mxi_q[i-1][2*j];
                assign mn_d[i][j]  = tmn ? mn_q[i-1][2*j+1] : mn_q[i-1][2*j];
                assign mni_d[i][j] = tmn ? mni_q[i-1][2*j+1] : mni_q[i-1][2*j];
                assign pr_d[i][j]  = pr_q[i-1][2*j] | pr_q[i-1][2*j+1];
                assign nn_d[i][j]  = nn_q[i-1][2*j] | nn_q[i-1][2*j+1];
            end else begin : g_pad
                assign mx_d[i][j]  = '0;
                assign mn_d[i][j]  = '0;
                assign mxi_d[i][j] = '0;
                assign mni_d[i][j] = '0;
                assign pr_d[i][j]  = 1'b0;
                assign nn_d[i][j]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i <= L; i++) begin
                for (int j = 0; j < P; j++) begin
                    mx_q[i][j]  <= '0;
                    mn_q[i][j]  <= '0;
                    mxi_q[i][j] <= '0;
                    mni_q[i][j] <= '0;
                    pr_q[i][j]  <= 1'b0;
                    nn_q[i][j]  <= 1'b0;
                end
            end
        end else if (adv) begin
            vld[0] <= valid_in;
            for (int i = 1; i <= L; i++)
                vld[i] <= vld[i-1];
            for (int i = 0; i <= L; i++) begin
                if (i > 0 || valid_in) begin
                    for (int j = 0; j < P; j++) begin
                        mx_q[i][j]  <= mx_d[i][j];
                        mn_q[i][j]  <= mn_d[i][j];
                        mxi_q[i][j] <= mxi_d[i][j];
                        mni_q[i][j] <= mni_d[i][j];
                        pr_q[i][j]  <= pr_d[i][j];
                        nn_q[i][j]  <= nn_d[i][j];
                    end
                end
            end
        end
    end

    assign valid_out = vld[L];
    assign adv       = !valid_out || out_ready;
    assign in_ready  = adv;
    assign nan       = nn_q[L][0];
    assign max       = nan ? QNAN : mx_q[L][0];
    assign min       = nan ? QNAN : mn_q[L][0];
    assign max_idx   = nan ? '0 : mxi_q[L][0];
    assign min_idx   = nan ? '0 : mni_q[L][0];
endmodule

// File: tb/tb_fp_maxmin_pipe.sv
// tb_fp_maxmin_pipe: scoreboard bench for fp_maxmin_pipe at N_CH=3, plus latency spot checks at N_CH=5 and N_CH=1
module tb_fp_maxmin_pipe;
    typedef struct packed {
        logic [31:0] mx, mn;
        logic [1:0]  mxi, mni;
        logic        nan, lat;
        int          cyc;
    } res_t;

    logic clk = 0, rst = 1;
    logic valid_in = 0, out_ready = 1;
    logic [95:0] data_in = '0;
    logic in_ready, valid_out, nan;
    logic [31:0] max, min;
    logic [1:0] max_idx, min_idx;

    logic v5 = 0, or5 = 1, r5, vo5, nan5;
    logic [159:0] d5 = '0;
    logic [31:0] mx5, mn5;
    logic [2:0] mxi5, mni5;

    logic v1 = 0, or1 = 1, r1, vo1, nan1;
    logic [31:0] d1 = '0;
    logic [31:0] mx1, mn1;
    logic mxi1, mni1;

    int total = 0, bad = 0, cyc = 0, npop = 0, lat;
    logic acc = 0, lat_mode = 0, hold = 0;
    logic [31:0] hmax, hmin;
    res_t q[$];

    always #5 clk = ~clk;

    fp_maxmin_pipe #(.N_CH(3)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready), .data_in(data_in),
        .valid_out(valid_out), .out_ready(out_ready), .max(max), .min(min),
        .max_idx(max_idx), .min_idx(min_idx), .nan(nan));
    fp_maxmin_pipe #(.N_CH(5)) dut5 (
        .clk(clk), .rst(rst), .valid_in(v5), .in_ready(r5), .data_in(d5),
        .valid_out(vo5), .out_ready(or5), .max(mx5), .min(mn5),
        .max_idx(mxi5), .min_idx(mni5), .nan(nan5));
    fp_maxmin_pipe #(.N_CH(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(v1), .in_ready(r1), .data_in(d1),
        .valid_out(vo1), .out_ready(or1), .max(mx1), .min(mn1),
        .max_idx(mxi1), .min_idx(mni1), .nan(nan1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction

    // a < b in IEEE order, both zeros equal
    function automatic logic lt(input logic [31:0] a, input logic [31:0] b);
        logic na = a[31] && a[30:0] != 0;
        logic nb = b[31] && b[30:0] != 0;
        if (na != nb) return na;
        if (!na) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic res_t model(input logic [95:0] d);
        res_t r = '0;
        logic [31:0] v[3];
        for (int k = 0; k < 3; k++) begin
            v[k] = d[k*32 +: 32];
            r.nan |= is_nan(v[k]);
        end
        for (int k = 1; k < 3; k++) begin
            if (lt(v[r.mxi], v[k])) r.mxi = 2'(k);
            if (lt(v[k], v[r.mni])) r.mni = 2'(k);
        end
        r.mx = v[r.mxi];
        r.mn = v[r.mni];
        if (r.nan) begin
            r.mx = 32'h7FC00000;
            r.mn = 32'h7FC00000;
            r.mxi = 0;
            r.mni = 0;
        end
        return r;
    endfunction

    task automatic step();
        res_t e;
        #1;
        if (hold) begin
            check("hold_vo", valid_out, 1);
            check("hold_max", max, hmax);
            check("hold_min", min, hmin);
        end
        check("in_ready", in_ready, !(valid_out && !out_ready));
        if (valid_out && out_ready) begin
            if (q.size() == 0) check("spurious_vo", valid_out, 0);
            else begin
                e = q.pop_front();
                npop++;
                check("max", max, e.mx);
                check("min", min, e.mn);
                check("max_idx", max_idx, e.mxi);
                check("min_idx", min_idx, e.mni);
                check("nan", nan, e.nan);
                if (e.lat) check("latency", cyc - e.cyc, 3);
            end
        end
        acc = valid_in && in_ready;
        if (acc) begin
            e = model(data_in);
            e.lat = lat_mode;
            e.cyc = cyc;
            q.push_back(e);
        end
        hold = valid_out && !out_ready;
        hmax = max;
        hmin = min;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    logic [95:0] dir[6] = '{
        {32'hBF800000, 32'h40000000, 32'h3F800000},
        {32'hC0400000, 32'hBF800000, 32'hC0000000},
        {32'h40400000, 32'h40400000, 32'h40400000},
        {32'h80000000, 32'h00000000, 32'h80000000},
        {32'hFF800000, 32'h7FC00001, 32'h3F800000},
        {32'h00000000, 32'h7F800000, 32'hFF800000}};
    logic [95:0] vecs[6];

    initial begin
        int vi, p0;
        #3;
        check("rst_vo", valid_out, 0);
        check("rst_max", max, 0);
        check("rst_min", min, 0);
        check("rst_idx", {max_idx, min_idx}, 0);
        check("rst_nan", nan, 0);
        @(negedge clk);
        rst = 0;

        check("first_max_const", model(dir[0]).mx, 32'h40000000);
        lat_mode = 1;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1;
            data_in = dir[i];
            step();
            valid_in = 0;
            repeat (4) step();
        end
        lat_mode = 0;
        check("directed_count", npop, 6);

        for (int k = 0; k < 6; k++) vecs[k] = {$urandom, $urandom, $urandom};
        vecs[2][31] = 1'b1;
        vi = 0;
        p0 = npop;
        for (int c = 0; c < 60 && (vi < 6 || q.size() > 0); c++) begin
            out_ready = !(c >= 4 && c <= 8);
            valid_in = vi < 6;
            data_in = vi < 6 ? vecs[vi] : '0;
            step();
            if (acc) vi++;
        end
        valid_in = 0;
        out_ready = 1;
        check("stream_count", npop - p0, 6);
        check("stream_drained", q.size(), 0);

        for (int k = 0; k < 3; k++) begin
            valid_in = 1;
            data_in = dir[k];
            step();
        end
        valid_in = 0;
        check("pre_rst_vo", valid_out, 1);
        #2 rst = 1;
        #1;
        check("async_rst_vo", valid_out, 0);
        check("async_rst_max", max, 0);
        #1 rst = 0;
        q.delete();
        hold = 0;
        @(negedge clk);
        repeat (6) step();
        check("post_rst_vo", valid_out, 0);

        v5 = 1;
        d5 = {32'hC0800000, 32'h3F000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
        check("d5_ready", r5, 1);
        step();
        v5 = 0;
        lat = 1;
        while (!vo5 && lat < 12) begin
            step();
            lat++;
        end
        check("d5_latency", lat, 4);
        check("d5_max", mx5, 32'h40000000);
        check("d5_max_idx", mxi5, 1);
        check("d5_min", mn5, 32'hC0800000);
        check("d5_min_idx", mni5, 4);
        check("d5_nan", nan5, 0);
        step();
        check("d5_one_cycle", vo5, 0);

        v1 = 1;
        d1 = 32'hBF800000;
        step();
        v1 = 0;
        lat = 1;
        while (!vo1 && lat < 12) begin
            step();
            lat++;
        end
        check("d1_latency", lat, 1);
        check("d1_max", mx1, 32'hBF800000);
        check("d1_min", mn1, 32'hBF800000);
        check("d1_idx", {mxi1, mni1}, 0);
        check("d1_nan", nan1, 0);
        step();
        check("d1_one_cycle", vo1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
